// File: rtl/approx_sum_accumulator16.sv
// Purpose: accumulates BLOCK_LEN unsigned 17-bit adder sums and presents the block total (APPROX_ACC_SAT_EN selects saturation).
// Latency: total valid one cycle after the last accept; HOLD lasts at least one cycle.
// Backpressure: sum_ready_o is low in HOLD or under clear_i; the total holds until acc_ready_i.
module approx_sum_accumulator16 #(
    parameter int ACC_W     = 24,
    parameter int BLOCK_LEN = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sum_valid_i,
    input  logic [16:0]      sum_i,
    output logic             sum_ready_o,
    input  logic             clear_i,
    output logic             acc_valid_o,
    output logic [ACC_W-1:0] acc_o,
    input  logic             acc_ready_i,
    output logic [8:0]       count_o,
    output logic             overflow_o
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [8:0] LAST_CNT = 9'(BLOCK_LEN - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [8:0]       count;
    logic             overflow;
    logic             acc_valid;

    logic             accept;
    logic [ACC_W-1:0] next_acc;
    logic             next_ovf;

    assign sum_ready_o = (state == ACCUM) && !clear_i;
    assign accept      = sum_valid_i && sum_ready_o;

`ifdef APPROX_ACC_SAT_EN
    logic [ACC_W:0] acc_sum;
    assign acc_sum = {1'b0, acc} + (ACC_W+1)'(sum_i);

    // Once saturated, the total stays pinned at all-ones for the rest of the block.
    always_comb begin
        next_acc = acc_sum[ACC_W-1:0];
        next_ovf = overflow;
        if (overflow || acc_sum[ACC_W]) begin
            next_acc = '1;
            next_ovf = 1'b1;
        end
    end
`else
    assign next_acc = acc + ACC_W'(sum_i);
    assign next_ovf = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            acc_valid <= 1'b0;
        end else if (clear_i) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc      <= next_acc;
                        overflow <= next_ovf;
                        count    <= count + 9'd1;
                        if (count == LAST_CNT) begin
                            state     <= HOLD;
                            acc_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Handshake empties the block; the next sum is taken no earlier than the following cycle.
                    if (acc_ready_i) begin
                        state     <= ACCUM;
                        acc       <= '0;
                        count     <= '0;
                        overflow  <= 1'b0;
                        acc_valid <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign acc_o       = acc;
    assign count_o     = count;
    assign overflow_o  = overflow;
    assign acc_valid_o = acc_valid;

endmodule

// File: tb/tb_approx_sum_accumulator16.sv
// Bench for approx_sum_accumulator16: a default instance (24-bit, 16 sums) and a small one (18-bit, 4 sums)
// share one input stream and are compared against a block-total model; honours APPROX_ACC_SAT_EN.
module tb_approx_sum_accumulator16;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        sum_valid_i;
    logic [16:0] sum_i;
    logic        clear_i;
    logic        acc_ready_i;

    logic        ready0, accv0, ovf0;
    logic [23:0] acc0;
    logic [8:0]  cnt0;
    logic        ready1, accv1, ovf1;
    logic [17:0] acc1;
    logic [8:0]  cnt1;

    int vectors     = 0;
    int comparisons = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    approx_sum_accumulator16 #(.ACC_W(24), .BLOCK_LEN(16)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .sum_valid_i(sum_valid_i), .sum_i(sum_i),
        .sum_ready_o(ready0), .clear_i(clear_i), .acc_valid_o(accv0), .acc_o(acc0),
        .acc_ready_i(acc_ready_i), .count_o(cnt0), .overflow_o(ovf0)
    );

    approx_sum_accumulator16 #(.ACC_W(18), .BLOCK_LEN(4)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .sum_valid_i(sum_valid_i), .sum_i(sum_i),
        .sum_ready_o(ready1), .clear_i(clear_i), .acc_valid_o(accv1), .acc_o(acc1),
        .acc_ready_i(acc_ready_i), .count_o(cnt1), .overflow_o(ovf1)
    );

    // Model: the true (unbounded) sum of the accepted beats of the current block.
    int     m_w[2]  = '{24, 18};
    int     m_bl[2] = '{16, 4};
    longint m_tot[2];
    int     m_cnt[2];
    bit     m_hold[2];

`ifdef APPROX_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    function automatic longint max_of(int i);
        return (longint'(1) << m_w[i]) - 1;
    endfunction

    function automatic longint exp_acc(int i);
        if (SAT) return (m_tot[i] > max_of(i)) ? max_of(i) : m_tot[i];
        return m_tot[i] & max_of(i);
    endfunction

    function automatic bit exp_ovf(int i);
        return SAT && (m_tot[i] > max_of(i));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_tot[i] = 0; m_cnt[i] = 0; m_hold[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit v, input logic [16:0] s, input bit c, input bit r);
        for (int i = 0; i < 2; i++) begin
            if (c || (m_hold[i] && r)) begin
                m_tot[i] = 0; m_cnt[i] = 0; m_hold[i] = 1'b0;
            end else if (!m_hold[i] && v) begin
                m_tot[i] += longint'(s);
                m_cnt[i]++;
                if (m_cnt[i] == m_bl[i]) m_hold[i] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        comparisons++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("acc0",  64'(acc0),  64'(exp_acc(0)));
        chk("accv0", 64'(accv0), 64'(m_hold[0]));
        chk("cnt0",  64'(cnt0),  64'(m_cnt[0]));
        chk("ovf0",  64'(ovf0),  64'(exp_ovf(0)));
        chk("acc1",  64'(acc1),  64'(exp_acc(1)));
        chk("accv1", 64'(accv1), 64'(m_hold[1]));
        chk("cnt1",  64'(cnt1),  64'(m_cnt[1]));
        chk("ovf1",  64'(ovf1),  64'(exp_ovf(1)));
    endtask

    task automatic step(input bit v, input logic [16:0] s, input bit c, input bit r);
        sum_valid_i = v; sum_i = s; clear_i = c; acc_ready_i = r;
        #1;
        chk("ready0", 64'(ready0), 64'(!m_hold[0] && !c));
        chk("ready1", 64'(ready1), 64'(!m_hold[1] && !c));
        @(posedge clk_i);
        model_edge(v, s, c, r);
        vectors++;
        #1;
        check_outputs();
    endtask

    initial begin
        rst_ni = 1'b0; sum_valid_i = 1'b0; sum_i = '0; clear_i = 1'b0; acc_ready_i = 1'b0;
        model_reset();
        #2;
        check_outputs();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("ready0_after_rst", 64'(ready0), 64'd1);

        // Back-to-back block of 0x29AF+0x7A1B
        for (int i = 0; i < 16; i++) step(1'b1, 17'h0A3CA, 1'b0, 1'b1);
        chk("blk_acc",   64'(acc0),  64'h0A3CA0);
        chk("blk_cnt",   64'(cnt0),  64'd16);
        chk("blk_valid", 64'(accv0), 64'd1);
        chk("blk_ovf",   64'(ovf0),  64'd0);
        step(1'b0, 17'h0, 1'b0, 1'b1);
        chk("blk_valid_drop", 64'(accv0), 64'd0);
        step(1'b0, 17'h0, 1'b0, 1'b1);

        // Backpressure in HOLD
        step(1'b0, 17'h0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 17'h00001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 17'h00001, 1'b0, 1'b0);
            chk("bp_ready", 64'(ready0), 64'd0);
            chk("bp_acc",   64'(acc0),   64'h10);
        end
        step(1'b1, 17'h00001, 1'b0, 1'b1);
        chk("bp_handshake_cnt", 64'(cnt0), 64'd0);
        step(1'b1, 17'h00001, 1'b0, 1'b1);
        chk("bp_first_cnt", 64'(cnt0), 64'd1);

        // Gapped input: only valid beats count
        step(1'b0, 17'h0, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) step(!i[0], 17'(i / 2), 1'b0, 1'b0);
        chk("gap_acc",   64'(acc0),  64'h78);
        chk("gap_valid", 64'(accv0), 64'd1);

        // Clear mid-block drops the partial total and the clear-cycle beat
        step(1'b0, 17'h0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 17'h00005, 1'b0, 1'b1);
        step(1'b1, 17'h1FFFE, 1'b1, 1'b1);
        chk("clr_cnt", 64'(cnt0), 64'd0);
        chk("clr_acc", 64'(acc0), 64'd0);
        step(1'b0, 17'h0, 1'b0, 1'b1);
        chk("clr_beat_dropped", 64'(cnt0), 64'd0);

        // Overflow on the 18-bit, 4-sum instance
        step(1'b0, 17'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 17'h1FFFE, 1'b0, 1'b0);
`ifdef APPROX_ACC_SAT_EN
        chk("ovf_acc", 64'(acc1), 64'h3FFFF);
        chk("ovf_flag", 64'(ovf1), 64'd1);
`else
        chk("ovf_acc", 64'(acc1), 64'h3FFF8);
        chk("ovf_flag", 64'(ovf1), 64'd0);
`endif

        // Randomized traffic
        step(1'b0, 17'h0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            logic [16:0] s;
            s = ($urandom_range(0, 1) == 1) ? 17'(32'h1FF00 | $urandom_range(0, 255))
                                            : 17'($urandom_range(0, 131071));
            step($urandom_range(0, 3) != 0, s, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset while holding a total
        step(1'b0, 17'h0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 17'h00100, 1'b0, 1'b0);
        chk("pre_rst_valid", 64'(accv0), 64'd1);
        sum_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("rst_ready0", 64'(ready0), 64'd1);
        chk("rst_ready1", 64'(ready1), 64'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 17'h00003, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
